vram_write_scheduler: RTL
=========================

// Module: vram_write_scheduler
// PURPOSE
//   Drains the VRAM write FIFO and issues one write at a time to the VRAM SRAM controller.
//   Arbitrates VRAM ownership between these CPU-originated writes and the display fetch path.
//   The display path always wins at an idle boundary. A write in flight is never pre-empted.
//   Sits between the FIFO read port and the SRAM controller request port.
// PARAMETERS
//   DATA_WIDTH      16    width of write data; matches the FIFO
//   ADDRESS_WIDTH   16    width of VRAM word address; matches the FIFO
//   TIMEOUT_CYCLES  64    max cycles in WRITE waiting for ram_done before abort (>=2)
//   COUNT_WIDTH     16    width of completed-write counter
// PORTS
//   clk                 in   1    system clock, all logic on rising edge
//   reset               in   1    synchronous, active-high
//   fifo_empty          in   1    FIFO has no entries
//   fifo_read_address   in   AW   FIFO head address (fall-through, valid when !fifo_empty)
//   fifo_read_data      in   DW   FIFO head data (fall-through)
//   fifo_read_request   out  1    pop strobe, one cycle per accepted entry
//   display_request     in   1    display fetch needs VRAM; level, held until done
//   display_grant       out  1    display owns VRAM
//   ram_request         out  1    write request to SRAM controller; level
//   ram_write_enable    out  1    high with ram_request (this block only writes)
//   ram_address         out  AW   write address, stable while ram_request
//   ram_data            out  DW   write data, stable while ram_request
//   ram_done            in   1    one-cycle pulse from controller: write committed
//   write_count         out  CW   completed writes, wraps modulo 2^CW
//   timeout_error       out  1    sticky: a write was aborted on timeout
// BEHAVIOUR
//   Reset values:
//     - state=IDLE; all outputs 0, including regs, counter and sticky flag.
//   FSM states: IDLE, WRITE, RECOVER, DISPLAY.
//   IDLE:
//     - display_request=1: go to DISPLAY. Takes priority over the FIFO.
//     - else if !fifo_empty: pop and go to WRITE.
//     - else stay.
//   Pop:
//     - fifo_read_request = (state==IDLE && !display_request && !fifo_empty && !reset).
//     - Combinational decode, so exactly one pulse per entry.
//     - ram_address/ram_data latch fifo_read_* on the same edge.
//   WRITE:
//     - ram_request=ram_write_enable=1 (registered). First asserted the cycle after the pop.
//     - ram_address and ram_data are held constant.
//     - ram_done=1: write_count+1, go to RECOVER.
//     - Timeout counter reaches TIMEOUT_CYCLES-1 without ram_done: set timeout_error, go to RECOVER.
//       The entry is dropped and write_count is not incremented.
//   RECOVER:
//     - One cycle with ram_request=0 so the controller sees the request deassert.
//     - Then go to IDLE.
//   DISPLAY:
//     - display_grant=1 (registered), asserted the cycle after the request is seen.
//     - Stay while display_request=1; go to IDLE when it drops. Grant falls on that edge.
//     - No pops occur while in DISPLAY.
//   Latency:
//     - Pop at cycle N, ram_request high at N+1.
//     - ram_done at M: ram_request low at M+1, IDLE at M+2, next pop possible at M+2.
//   Boundary conditions:
//     - display_request rising during WRITE: the write completes, then RECOVER, then IDLE.
//       Grant follows one cycle later.
//     - ram_done outside WRITE is ignored.
//     - fifo_empty is only sampled in IDLE.
//     - write_count wraps from all-ones to 0.
//     - timeout_error is cleared only by reset.
//   Reset mid-operation:
//     - Next edge: IDLE, ram_request=0, display_grant=0.
//     - An entry already popped is discarded. The FIFO is reset alongside this block.
// TESTING
//   1. Reset, then one entry addr=0x4000 data=0xBEEF with ram_done 3 cycles after request
//      -> one pop; ram_request for 3 cycles; ram_address=0x4000, ram_data=0xBEEF; write_count=1.
//   2. 8 back-to-back FIFO entries with ram_done after 1 cycle
//      -> 8 pops in order, spaced 3 cycles apart; write_count=8; fifo_empty at end.
//   3. display_request and fifo non-empty in the same IDLE cycle
//      -> no pop; display_grant next cycle. Drop display_request -> grant falls; pop 1 cycle later.
//   4. display_request rises mid-WRITE
//      -> ram_request held until ram_done; grant 3 cycles after ram_done; no second pop.
//   5. TIMEOUT_CYCLES=8 and ram_done never returned
//      -> ram_request drops after 8 cycles; timeout_error=1 and stays; write_count unchanged.
//   6. Reset asserted in WRITE, and write_count preset to 0xFFFF then one more write
//      -> all outputs 0 next cycle; wrap case gives write_count=0x0000.

Source files
------------

// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler: drains the VRAM write FIFO into the SRAM controller, yielding to display fetch at idle boundaries
module vram_write_scheduler #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fifo_empty,
    input  logic [ADDRESS_WIDTH-1:0] fifo_read_address,
    input  logic [DATA_WIDTH-1:0]    fifo_read_data,
    output logic                     fifo_read_request,
    input  logic                     display_request,
    output logic                     display_grant,
    output logic                     ram_request,
    output logic                     ram_write_enable,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_data,
    input  logic                     ram_done,
    output logic [COUNT_WIDTH-1:0]   write_count,
    output logic                     timeout_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, WRITE, RECOVER, DISPLAY} state_t;
    state_t                   state_q, state_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic                     req_q, req_d;
    logic                     grant_q, grant_d;
    logic                     err_q, err_d;
    assign fifo_read_request = state_q == IDLE && !display_request && !fifo_empty && !reset;
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        req_d   = req_q;
        grant_d = grant_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (display_request) begin
                    state_d = DISPLAY;
                    grant_d = 1'b1;
                end else if (!fifo_empty) begin
                    state_d = WRITE;
                    req_d   = 1'b1;
                    tmo_d   = '0;
                    addr_d  = fifo_read_address;
                    data_d  = fifo_read_data;
                end
            end
            WRITE: begin
                // a completion on the last allowed cycle still counts as a successful write
                if (ram_done) begin
                    state_d = RECOVER;
                    req_d   = 1'b0;
                    count_d = count_q + 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = RECOVER;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RECOVER: state_d = IDLE;
            DISPLAY: begin
                if (!display_request) begin
                    state_d = IDLE;
                    grant_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            req_q   <= 1'b0;
            grant_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            req_q   <= req_d;
            grant_q <= grant_d;
            err_q   <= err_d;
        end
    end
    assign ram_request      = req_q;
    assign ram_write_enable = req_q;
    assign ram_address      = addr_q;
    assign ram_data         = data_q;
    assign write_count      = count_q;
    assign display_grant    = grant_q;
    assign timeout_error    = err_q;
endmodule
